// File: rtl/spi_slave_counter_rx.sv
// SPI mode 0 slave that receives a two-byte 14-bit counter frame on the system clock.
// Optional miso echo of the last accepted value is built when SPI_SLAVE_ECHO_EN is defined.
module spi_slave_counter_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss,
    output logic        miso,
    output logic [13:0] o_counter,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StRxHigh  = 3'b001,
        StRxLow   = 3'b010,
        StWaitEnd = 3'b011
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_idx_q, byte_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  high_q, high_d;
    logic [7:0]  low_q, low_d;
    logic        overrun_q, overrun_d;
    logic [13:0] counter_q, counter_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        high_d     = high_q;
        low_d      = low_q;
        overrun_d  = overrun_q;
        counter_d  = counter_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        // The sclk edge is applied first; the ss rise below then sees the updated state.
        case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = 1'b0;
                    shift_d    = 8'h00;
                    overrun_d  = 1'b0;
                    state_d    = StRxHigh;
                end
            end
            StRxHigh, StRxLow: begin
                if (sclk_rise) begin
                    shift_d   = {shift_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (!byte_idx_q) begin
                            high_d     = shift_d;
                            byte_idx_d = 1'b1;
                            state_d    = StRxLow;
                        end else begin
                            low_d   = shift_d;
                            state_d = StWaitEnd;
                        end
                    end
                end
            end
            StWaitEnd: begin
                if (sclk_rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ss_rise) begin
            case (state_d)
                StRxHigh, StRxLow: begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
                StWaitEnd: begin
                    if (overrun_d || (high_d[7:6] != 2'b00)) begin
                        err_d = 1'b1;
                    end else begin
                        counter_d = {high_d[5:0], low_d};
                        valid_d   = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 1'b0;
            shift_q    <= 8'h00;
            high_q     <= 8'h00;
            low_q      <= 8'h00;
            overrun_q  <= 1'b0;
            counter_q  <= 14'h0000;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            high_q     <= high_d;
            low_q      <= low_d;
            overrun_q  <= overrun_d;
            counter_q  <= counter_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

`ifdef SPI_SLAVE_ECHO_EN
    logic [7:0] tx_q, tx_d;

    // No shift on the fall right after a byte boundary: the reload already presents bit 7.
    always_comb begin
        tx_d = tx_q;
        if (state_q != StRxHigh && state_d == StRxHigh) begin
            tx_d = {2'b00, counter_q[13:8]};
        end else if (state_q == StRxHigh && state_d == StRxLow) begin
            tx_d = counter_q[7:0];
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q <= 8'h00;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign miso = (state_q == StIdle) ? 1'b0 : tx_q[7];
`else
    assign miso = 1'b0;
`endif

    assign o_counter   = counter_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_spi_slave_counter_rx.sv
// Scoreboard bench for spi_slave_counter_rx: directed frames push expected pulses,
// a negedge monitor pops and compares them.
module tb_spi_slave_counter_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss = 1'b1;
    logic        miso;
    logic [13:0] o_counter;
    logic        o_valid;
    logic        o_frame_err;
    logic [2:0]  o_state;

    spi_slave_counter_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .mosi        (mosi),
        .ss          (ss),
        .miso        (miso),
        .o_counter   (o_counter),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_valid;
        logic [13:0] cnt;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         ev_mon;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [13:0] model_cnt = 14'h0000;
    logic [31:0] echo = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_valid(input logic [13:0] c);
        ev_t e;
        e.is_valid = 1'b1;
        e.cnt      = c;
        model_cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.is_valid = 1'b0;
        e.cnt      = model_cnt;
        exp_q.push_back(e);
    endtask

    // Sends the n LSBs of data MSB first; rst_at >= 0 pulses reset while that bit's sclk is high.
    task automatic send_bits(input logic [31:0] data, input int n, input int rst_at);
        ss = 1'b0;
        tick(8);
        for (int i = 0; i < n; i++) begin
            mosi = data[n-1-i];
            tick(8);
            sclk = 1'b1;
            echo = {echo[30:0], miso};
            if (i == rst_at) begin
                tick(2);
                reset = 1'b1;
                tick(2);
                reset = 1'b0;
                model_cnt = 14'h0000;
                tick(1);
                chk("rst_counter", {18'h0, o_counter}, 32'h0);
                chk("rst_state", {29'h0, o_state}, 32'h0);
            end
            tick(8);
            sclk = 1'b0;
        end
        tick(8);
        ss = 1'b1;
        tick(10);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        chk(name, exp_q.size(), 32'h0);
        chk({name, "_state"}, {29'h0, o_state}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (o_valid || o_frame_err) begin
            chk("exclusive", {31'h0, o_valid & o_frame_err}, 32'h0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'h1, 32'h0);
            end else begin
                ev_mon = exp_q.pop_front();
                chk("pulse_kind", {31'h0, o_valid}, {31'h0, ev_mon.is_valid});
                chk("pulse_counter", {18'h0, o_counter}, {18'h0, ev_mon.cnt});
            end
        end
    end

    initial begin
        tick(4);
        chk("reset_counter", {18'h0, o_counter}, 32'h0);
        chk("reset_valid", {31'h0, o_valid}, 32'h0);
        chk("reset_err", {31'h0, o_frame_err}, 32'h0);
        chk("reset_state", {29'h0, o_state}, 32'h0);
        chk("reset_miso", {31'h0, miso}, 32'h0);
        reset = 1'b0;
        tick(10);

        push_valid(14'h2A5C);
        send_bits({16'h0, 8'h2A, 8'h5C}, 16, -1);
        drain("nominal");

`ifdef SPI_SLAVE_ECHO_EN
        push_valid(14'h0000);
        send_bits(32'h0, 16, -1);
        drain("echo_frame");
        chk("echo_miso", {16'h0, echo[15:0]}, 32'h2A5C);
`endif

        push_err();
        send_bits({19'h0, 8'h12, 5'b10101}, 13, -1);
        drain("short");
        chk("short_hold", {18'h0, o_counter}, {18'h0, model_cnt});

        push_err();
        send_bits({16'h0, 8'hC1, 8'h00}, 16, -1);
        drain("bad_header");

        push_err();
        send_bits({15'h0, 8'h00, 8'h00, 1'b0}, 17, -1);
        drain("overrun");

        push_valid(14'h3FFF);
        send_bits({16'h0, 8'h3F, 8'hFF}, 16, -1);
        drain("after_overrun");

        send_bits({16'h0, 8'h55, 8'hAA}, 16, 9);
        drain("aborted");

        push_valid(14'h0001);
        send_bits({16'h0, 8'h00, 8'h01}, 16, -1);
        drain("after_reset");
        chk("final_counter", {18'h0, o_counter}, 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
